// File: rtl/xor_frame_parity_pkg.sv
// rtl/xor_frame_parity_pkg.sv - shared state encoding and count-width helper for xor_frame_parity
package xor_frame_parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Never returns zero, so a degenerate MAX_LEN still yields a usable vector.
    function automatic int cnt_width(input int max_len);
        return (max_len < 1) ? 1 : $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/xor_reduce.sv
// rtl/xor_reduce.sv - parametrised WIDTH-input XOR reduction gate
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);

    assign o_bit = ^i_data;

endmodule

// File: rtl/xor_frame_parity.sv
// rtl/xor_frame_parity.sv - frame-wise column XOR over a valid/ready stream; XOR_FRAME_PARITY_CHECK_EN adds expected-parity compare
module xor_frame_parity
    import xor_frame_parity_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic [WIDTH-1:0]                 IN_DATA,
    input  logic                             IN_LAST,
`ifdef XOR_FRAME_PARITY_CHECK_EN
    input  logic [WIDTH-1:0]                 IN_PARITY,
    output logic                             OUT_ERR,
`endif
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [WIDTH-1:0]                 OUT_PARITY,
    output logic                             OUT_BIT,
    output logic [cnt_width(MAX_LEN)-1:0]    OUT_COUNT,
    output logic                             OUT_OVF
);

    localparam int CW = cnt_width(MAX_LEN);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [WIDTH-1:0] w_next_acc;

    assign IN_READY   = (r_state != HOLD);
    assign OUT_VALID  = (r_state == HOLD);
    assign w_in_fire  = IN_VALID & IN_READY;
    assign w_out_fire = OUT_VALID & OUT_READY;
    // The first beat of a frame replaces the accumulator rather than folding into it.
    assign w_next_acc = (r_state == IDLE) ? IN_DATA : (r_acc ^ IN_DATA);

    assign OUT_PARITY = r_acc;
    assign OUT_COUNT  = r_cnt;
    assign OUT_OVF    = r_ovf;

    xor_reduce #(.WIDTH(WIDTH)) u_bit_reduce (
        .i_data (r_acc),
        .o_bit  (OUT_BIT)
    );

`ifdef XOR_FRAME_PARITY_CHECK_EN
    logic r_err;
    assign OUT_ERR = r_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_out_fire) begin
            r_err <= 1'b0;
        end else if (w_in_fire && IN_LAST) begin
            r_err <= (w_next_acc != IN_PARITY);
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        r_acc   <= w_next_acc;
                        r_cnt   <= CW'(1);
                        r_ovf   <= 1'b0;
                        r_state <= IN_LAST ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_in_fire) begin
                        r_acc <= w_next_acc;
                        // Count saturates; further beats only raise the overflow flag.
                        if (r_cnt == CW'(MAX_LEN)) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (IN_LAST) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_out_fire) begin
                        r_state <= IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_frame_parity.sv
// tb/tb_xor_frame_parity.sv - directed self-checking bench for xor_frame_parity (MAX_LEN=4)
module tb_xor_frame_parity;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA = '0;
    logic             IN_LAST = 1'b0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [WIDTH-1:0] OUT_PARITY;
    logic             OUT_BIT;
    logic [2:0]       OUT_COUNT;
    logic             OUT_OVF;
`ifdef XOR_FRAME_PARITY_CHECK_EN
    logic [WIDTH-1:0] IN_PARITY = '0;
    logic             OUT_ERR;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    xor_frame_parity #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_DATA    (IN_DATA),
        .IN_LAST    (IN_LAST),
`ifdef XOR_FRAME_PARITY_CHECK_EN
        .IN_PARITY  (IN_PARITY),
        .OUT_ERR    (OUT_ERR),
`endif
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_PARITY (OUT_PARITY),
        .OUT_BIT    (OUT_BIT),
        .OUT_COUNT  (OUT_COUNT),
        .OUT_OVF    (OUT_OVF)
    );

    task automatic beat(input logic [7:0] d, input logic last);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        IN_LAST  = last;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    task automatic test_reset;
        #3 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({IN_READY, OUT_VALID, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF} !== {1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b par=%h bit=%b cnt=%0d ovf=%b want rdy=1 others 0",
                     IN_READY, OUT_VALID, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF);
        end
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_single;
        OUT_READY = 1'b0;
        beat(8'hA5, 1'b1);
        checks++;
        if ({OUT_VALID, IN_READY, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF} !== {1'b1, 1'b0, 8'hA5, 1'b0, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_result got vld=%b rdy=%b par=%h bit=%b cnt=%0d ovf=%b want 1 0 a5 0 1 0",
                     OUT_VALID, IN_READY, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF);
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        checks++;
        if ({OUT_VALID, IN_READY} !== 2'b01) begin
            errors++;
            $display("FAIL single_release got vld=%b rdy=%b want 0 1", OUT_VALID, IN_READY);
        end
    endtask

    task automatic test_three_beat;
        OUT_READY = 1'b1;
        beat(8'h0F, 1'b0);
        beat(8'hF0, 1'b0);
        checks++;
        if (OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL three_early_valid got %b want 0", OUT_VALID);
        end
        beat(8'h3C, 1'b1);
        checks++;
        if ({OUT_VALID, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF} !== {1'b1, 8'hC3, 1'b0, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL three_result got vld=%b par=%h bit=%b cnt=%0d ovf=%b want 1 c3 0 3 0",
                     OUT_VALID, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF);
        end
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        checks++;
        if ({OUT_VALID, IN_READY} !== 2'b01) begin
            errors++;
            $display("FAIL three_ready_again got vld=%b rdy=%b want 0 1", OUT_VALID, IN_READY);
        end
    endtask

    task automatic test_stall;
        OUT_READY = 1'b0;
        beat(8'h55, 1'b0);
        beat(8'h02, 1'b1);
        IN_VALID = 1'b1;
        IN_DATA  = 8'hFF;
        IN_LAST  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({IN_READY, OUT_VALID, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF} !== {1'b0, 1'b1, 8'h57, 1'b1, 3'd2, 1'b0}) begin
                errors++;
                $display("FAIL stall_cycle%0d got rdy=%b vld=%b par=%h bit=%b cnt=%0d ovf=%b want 0 1 57 1 2 0",
                         i, IN_READY, OUT_VALID, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF);
            end
            @(posedge CLK);
            #1;
        end
        IN_VALID  = 1'b0;
        IN_LAST   = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        checks++;
        if ({OUT_VALID, IN_READY, OUT_COUNT} !== {1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL stall_release got vld=%b rdy=%b cnt=%0d want 0 1 0", OUT_VALID, IN_READY, OUT_COUNT);
        end
    endtask

    task automatic test_overflow;
        OUT_READY = 1'b0;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h04, 1'b0);
        beat(8'h08, 1'b1);
        checks++;
        if ({OUT_PARITY, OUT_COUNT, OUT_OVF} !== {8'h0F, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL exact_max got par=%h cnt=%0d ovf=%b want 0f 4 0", OUT_PARITY, OUT_COUNT, OUT_OVF);
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        for (int i = 0; i < 6; i++) beat(8'h01, (i == 5));
        checks++;
        if ({OUT_VALID, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF} !== {1'b1, 8'h00, 1'b0, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL overflow got vld=%b par=%h bit=%b cnt=%0d ovf=%b want 1 00 0 4 1",
                     OUT_VALID, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF);
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset_abort;
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        RST = 1'b1;
        #2;
        checks++;
        if ({IN_READY, OUT_VALID, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF} !== {1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort_async got rdy=%b vld=%b par=%h bit=%b cnt=%0d ovf=%b want rdy=1 others 0",
                     IN_READY, OUT_VALID, OUT_PARITY, OUT_BIT, OUT_COUNT, OUT_OVF);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        beat(8'h81, 1'b1);
        checks++;
        if ({OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_OVF} !== {1'b1, 8'h81, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL abort_next got vld=%b par=%h cnt=%0d ovf=%b want 1 81 1 0",
                     OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_OVF);
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
    endtask

`ifdef XOR_FRAME_PARITY_CHECK_EN
    task automatic test_check;
        logic [7:0] exp_par [2];
        exp_par[0] = 8'h26;
        exp_par[1] = 8'h27;
        for (int i = 0; i < 2; i++) begin
            beat(8'h12, 1'b0);
            IN_PARITY = exp_par[i];
            beat(8'h34, 1'b1);
            checks++;
            if ({OUT_VALID, OUT_PARITY, OUT_ERR} !== {1'b1, 8'h26, (i == 1)}) begin
                errors++;
                $display("FAIL check_err%0d got vld=%b par=%h err=%b want 1 26 %0d",
                         i, OUT_VALID, OUT_PARITY, OUT_ERR, i);
            end
            OUT_READY = 1'b1;
            @(posedge CLK);
            #1;
            OUT_READY = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_three_beat;
        test_stall;
        test_overflow;
        test_reset_abort;
`ifdef XOR_FRAME_PARITY_CHECK_EN
        test_check;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
